// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer
// Brief    : Pong game-flow controller: serve/rally/point/match sequencing.
//            Optional rally speed-up enabled by defining SPEEDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module match_sequencer #(
    parameter logic [3:0]  WIN_SCORE     = 4'd9,
    parameter logic [15:0] NEWGAME_TICKS = 16'd4,
    parameter logic [15:0] SERVE_TICKS   = 16'd120,
    parameter logic [15:0] POINT_TICKS   = 16'd60,
    parameter logic [15:0] SPEEDUP_TICKS = 16'd600,
    parameter logic [1:0]  MAX_LEVEL     = 2'd3
) (
    input  logic       Yclock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [3:0] p0_score,
    input  logic [3:0] p1_score,
    output logic       inPlay,
    output logic       newGame,
    output logic       ball_reset,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] speed_level,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        c_idle   = 3'd0,
        c_new    = 3'd1,
        c_serve  = 3'd2,
        c_rally  = 3'd3,
        c_paused = 3'd4,
        c_point  = 3'd5,
        c_over   = 3'd6
    } state_t;

    // A zero tick count would never match, so it is promoted to one cycle.
    localparam logic [15:0] c_newgame_last = (NEWGAME_TICKS == 16'd0) ? 16'd0 : NEWGAME_TICKS - 16'd1;
    localparam logic [15:0] c_serve_last   = (SERVE_TICKS   == 16'd0) ? 16'd0 : SERVE_TICKS   - 16'd1;
    localparam logic [15:0] c_point_last   = (POINT_TICKS   == 16'd0) ? 16'd0 : POINT_TICKS   - 16'd1;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_phase_cnt;
    logic        r_start_q;
    logic        r_pause_q;
    logic [3:0]  r_p0_meta;
    logic [3:0]  r_p0_sync;
    logic [3:0]  r_p0_prev;
    logic [3:0]  r_p1_meta;
    logic [3:0]  r_p1_sync;
    logic [3:0]  r_p1_prev;
    logic        r_in_play;
    logic        r_new_game;
    logic        r_ball_reset;
    logic        r_game_over;
    logic        r_winner;

    logic w_start_edge;
    logic w_pause_edge;
    logic w_point_evt;
    logic w_match_won;
    logic w_restart;
    logic w_timed_state;

    assign w_start_edge  = start_btn & ~r_start_q;
    assign w_pause_edge  = pause_btn & ~r_pause_q;
    assign w_point_evt   = (r_p0_sync != r_p0_prev) | (r_p1_sync != r_p1_prev);
    assign w_match_won   = (r_p0_sync >= WIN_SCORE) | (r_p1_sync >= WIN_SCORE);
    assign w_restart     = w_start_edge & ((r_state == c_serve) | (r_state == c_rally) |
                                           (r_state == c_paused) | (r_state == c_point) |
                                           (r_state == c_over));
    assign w_timed_state = (r_state == c_new) | (r_state == c_serve) | (r_state == c_point);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_start_edge)
                    w_state_next = c_new;
            end
            c_new: begin
                if (r_phase_cnt >= c_newgame_last)
                    w_state_next = c_serve;
            end
            c_serve: begin
                if (r_phase_cnt >= c_serve_last)
                    w_state_next = c_rally;
            end
            c_rally: begin
                if (w_point_evt)
                    w_state_next = c_point;
                else if (w_pause_edge)
                    w_state_next = c_paused;
            end
            c_paused: begin
                if (w_pause_edge)
                    w_state_next = c_rally;
            end
            c_point: begin
                if (r_phase_cnt >= c_point_last)
                    w_state_next = w_match_won ? c_over : c_serve;
            end
            c_over: begin
                w_state_next = c_over;
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
        if (w_restart)
            w_state_next = c_new;
    end

    // Outputs are decoded from the destination state so they move with r_state.
    always_ff @(posedge Yclock or posedge reset) begin
        if (reset) begin
            r_state      <= c_idle;
            r_phase_cnt  <= 16'd0;
            r_start_q    <= 1'b0;
            r_pause_q    <= 1'b0;
            r_p0_meta    <= 4'd0;
            r_p0_sync    <= 4'd0;
            r_p0_prev    <= 4'd0;
            r_p1_meta    <= 4'd0;
            r_p1_sync    <= 4'd0;
            r_p1_prev    <= 4'd0;
            r_in_play    <= 1'b0;
            r_new_game   <= 1'b0;
            r_ball_reset <= 1'b1;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_start_q <= start_btn;
            r_pause_q <= pause_btn;
            r_state   <= w_state_next;

            if (w_state_next != r_state)
                r_phase_cnt <= 16'd0;
            else if (w_timed_state)
                r_phase_cnt <= r_phase_cnt + 16'd1;

            // Leaving NEW the dynamics scores are cleared, so history restarts at zero.
            if ((r_state == c_new) && (w_state_next != c_new)) begin
                r_p0_meta <= 4'd0;
                r_p0_sync <= 4'd0;
                r_p0_prev <= 4'd0;
                r_p1_meta <= 4'd0;
                r_p1_sync <= 4'd0;
                r_p1_prev <= 4'd0;
            end else begin
                r_p0_meta <= p0_score;
                r_p0_sync <= r_p0_meta;
                r_p0_prev <= r_p0_sync;
                r_p1_meta <= p1_score;
                r_p1_sync <= r_p1_meta;
                r_p1_prev <= r_p1_sync;
            end

            case (w_state_next)
                c_new: begin
                    r_in_play    <= 1'b0;
                    r_new_game   <= 1'b1;
                    r_ball_reset <= 1'b0;
                    r_game_over  <= 1'b0;
                    r_winner     <= 1'b0;
                end
                c_serve, c_paused, c_point: begin
                    r_in_play    <= 1'b0;
                    r_new_game   <= 1'b0;
                    r_ball_reset <= 1'b0;
                    r_game_over  <= 1'b0;
                end
                c_rally: begin
                    r_in_play    <= 1'b1;
                    r_new_game   <= 1'b0;
                    r_ball_reset <= 1'b0;
                    r_game_over  <= 1'b0;
                end
                c_over: begin
                    r_in_play    <= 1'b0;
                    r_new_game   <= 1'b0;
                    r_ball_reset <= 1'b1;
                    r_game_over  <= 1'b1;
                    if (r_state != c_over)
                        r_winner <= (r_p1_sync > r_p0_sync);
                end
                default: begin
                    r_in_play    <= 1'b0;
                    r_new_game   <= 1'b0;
                    r_ball_reset <= 1'b1;
                    r_game_over  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPEEDUP_EN
    localparam logic [15:0] c_speedup_last = (SPEEDUP_TICKS == 16'd0) ? 16'd0 : SPEEDUP_TICKS - 16'd1;

    logic [15:0] r_speed_cnt;
    logic [1:0]  r_speed_level;

    // Counts every edge spent in RALLY; PAUSED leaves both registers untouched.
    always_ff @(posedge Yclock or posedge reset) begin
        if (reset) begin
            r_speed_cnt   <= 16'd0;
            r_speed_level <= 2'd0;
        end else if ((w_state_next == c_new) || (w_state_next == c_point)) begin
            r_speed_cnt   <= 16'd0;
            r_speed_level <= 2'd0;
        end else if (r_state == c_rally) begin
            if (r_speed_cnt >= c_speedup_last) begin
                r_speed_cnt <= 16'd0;
                if (r_speed_level < MAX_LEVEL)
                    r_speed_level <= r_speed_level + 2'd1;
            end else begin
                r_speed_cnt <= r_speed_cnt + 16'd1;
            end
        end
    end

    assign speed_level = r_speed_level;
`else
    assign speed_level = 2'd0;
`endif

    assign inPlay     = r_in_play;
    assign newGame    = r_new_game;
    assign ball_reset = r_ball_reset;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_sequencer
// Brief    : Scoreboard bench for match_sequencer (works with or without SPEEDUP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_sequencer;

    logic       Yclock = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       pause_btn;
    logic [3:0] p0_score;
    logic [3:0] p1_score;
    logic       inPlay;
    logic       newGame;
    logic       ball_reset;
    logic       game_over;
    logic       winner;
    logic [1:0] speed_level;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int rally_n = 0;

    typedef struct {
        string      tag;
        logic [9:0] vec;
    } exp_t;

    exp_t sb_q[$];

    match_sequencer #(
        .WIN_SCORE     (4'd9),
        .NEWGAME_TICKS (16'd2),
        .SERVE_TICKS   (16'd4),
        .POINT_TICKS   (16'd2),
        .SPEEDUP_TICKS (16'd3),
        .MAX_LEVEL     (2'd3)
    ) u_dut (
        .Yclock      (Yclock),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .p0_score    (p0_score),
        .p1_score    (p1_score),
        .inPlay      (inPlay),
        .newGame     (newGame),
        .ball_reset  (ball_reset),
        .game_over   (game_over),
        .winner      (winner),
        .speed_level (speed_level),
        .state       (state)
    );

    always #5 Yclock = ~Yclock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected speed level after n rally edges with a 3-cycle step, capped at 3.
    function automatic logic [1:0] lvl(input int n);
        int l;
        l = n / 3;
        if (l > 3)
            l = 3;
        return l[1:0];
    endfunction

    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic ip,
                                input logic ng, input logic br, input logic go,
                                input logic wn, input logic [1:0] sl);
        exp_t       e;
        logic [1:0] sl_eff;
`ifdef SPEEDUP_EN
        sl_eff = sl;
`else
        sl_eff = 2'd0;
`endif
        e.tag = tag;
        e.vec = {st, ip, ng, br, go, wn, sl_eff};
        sb_q.push_back(e);
        @(negedge Yclock);
    endtask

    task automatic new_serve(input string tag);
        repeat (2) expect_cycle({tag, "_new"}, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (4) expect_cycle({tag, "_serve"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rally_n = 0;
        expect_cycle({tag, "_rally0"}, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic rally(input int k, input string tag);
        repeat (k) begin
            rally_n++;
            expect_cycle(tag, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lvl(rally_n));
        end
    endtask

    task automatic point_seq(input string tag, input logic to_over, input logic wn);
        repeat (2) expect_cycle({tag, "_point"}, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        if (to_over) begin
            expect_cycle({tag, "_over"}, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, wn, 2'd0);
        end else begin
            repeat (4) expect_cycle({tag, "_serve"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            rally_n = 0;
            expect_cycle({tag, "_rally0"}, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_state"},       {13'd0, state},       16'd0);
        check_eq({tag, "_inPlay"},      {15'd0, inPlay},      16'd0);
        check_eq({tag, "_newGame"},     {15'd0, newGame},     16'd0);
        check_eq({tag, "_ball_reset"},  {15'd0, ball_reset},  16'd1);
        check_eq({tag, "_game_over"},   {15'd0, game_over},   16'd0);
        check_eq({tag, "_winner"},      {15'd0, winner},      16'd0);
        check_eq({tag, "_speed_level"}, {14'd0, speed_level}, 16'd0);
    endtask

    // Winner is only meaningful while game_over is expected high.
    always @(posedge Yclock) begin : mon
        exp_t       e;
        logic [9:0] act;
        logic [9:0] expv;
        #1;
        if (sb_q.size() != 0) begin
            e    = sb_q.pop_front();
            act  = {state, inPlay, newGame, ball_reset, game_over, winner, speed_level};
            expv = e.vec;
            if (!expv[3]) begin
                act[2]  = 1'b0;
                expv[2] = 1'b0;
            end
            check_eq(e.tag, {6'd0, act}, {6'd0, expv});
        end
    end

    initial begin
        reset     = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        p0_score  = 4'd0;
        p1_score  = 4'd0;
        repeat (2) @(negedge Yclock);
        reset_checks("rst_init");
        reset = 1'b0;
        expect_cycle("idle", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        start_btn = 1'b1;
        new_serve("start");
        rally(4, "rally_a");

        // The edge that enters PAUSED is itself a rally cycle.
        pause_btn = 1'b1;
        rally_n++;
        expect_cycle("pause_in", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lvl(rally_n));
        pause_btn = 1'b0;
        repeat (10) expect_cycle("paused", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lvl(rally_n));
        pause_btn = 1'b1;
        expect_cycle("resume", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lvl(rally_n));
        pause_btn = 1'b0;
        rally(8, "rally_b");

        p1_score = 4'd1;
        rally(2, "pre_pt1");
        point_seq("pt1", 1'b0, 1'b0);

        rally(3, "rally_c");
        p0_score = 4'd1;
        rally(2, "pre_pt2");
        pause_btn = 1'b1;
        point_seq("pt_vs_pause", 1'b0, 1'b0);
        pause_btn = 1'b0;

        rally(2, "rally_d");
        p0_score = 4'd9;
        rally(2, "pre_win0");
        point_seq("win0", 1'b1, 1'b0);
        expect_cycle("over0_hold", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        start_btn = 1'b0;
        expect_cycle("over0_hold", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        start_btn = 1'b1;
        p0_score  = 4'd0;
        p1_score  = 4'd0;
        new_serve("restart");
        rally(2, "rally_e");
        p1_score = 4'd9;
        rally(2, "pre_win1");
        point_seq("win1", 1'b1, 1'b1);
        expect_cycle("over1_hold", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        start_btn = 1'b0;
        expect_cycle("over1_hold", 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);

        start_btn = 1'b1;
        p1_score  = 4'd0;
        repeat (2) expect_cycle("restart2_new", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (2) expect_cycle("restart2_serve", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        reset = 1'b1;
        #1;
        reset_checks("rst_serve");
        start_btn = 1'b0;
        @(negedge Yclock);
        reset = 1'b0;
        expect_cycle("idle2", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        start_btn = 1'b1;
        new_serve("start2");
        rally(5, "rally_f");
        reset = 1'b1;
        #1;
        reset_checks("rst_rally");
        @(negedge Yclock);
        reset     = 1'b0;
        start_btn = 1'b0;
        repeat (2) expect_cycle("idle3", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        @(negedge Yclock);
        check_eq("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
